// File: rtl/eth_speed_pkg.sv
// Shared speed encodings and controller state type for the receive-side
// link-speed controller.
package eth_speed_pkg;

  localparam logic [1:0] SPEED_10M  = 2'b00;
  localparam logic [1:0] SPEED_100M = 2'b01;
  localparam logic [1:0] SPEED_1G   = 2'b10;
  localparam logic [1:0] SPEED_RSVD = 2'b11;

  typedef enum logic [1:0] {
    RUN    = 2'd0,
    DRAIN  = 2'd1,
    SWITCH = 2'd2,
    SETTLE = 2'd3
  } ctrl_state_t;

  function automatic logic is_mii(input logic [1:0] spd);
    return spd != SPEED_1G;
  endfunction

endpackage

// File: rtl/eth_clk_en_gen.sv
// Receiver clock-enable strobe: constant at 1G, one pulse per DIV cycles at
// 100M/10M with the strobe high exactly when the divider count is zero.
module eth_clk_en_gen
  import eth_speed_pkg::*;
#(
  parameter int DIV_100M = 5,
  parameter int DIV_10M  = 50
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [1:0] i_speed,
  input  logic       i_clr,
  input  logic       i_gate,
  output logic       o_clk_en
);

  localparam int DIV_MAX = (DIV_10M > DIV_100M) ? DIV_10M : DIV_100M;
  localparam int DW      = $clog2(DIV_MAX);

  logic [DW-1:0] r_div_cnt;
  logic [DW-1:0] w_div_max;
  logic [DW-1:0] w_div_nxt;
  logic          r_clk_en;

  always_comb begin
    w_div_max = (i_speed == SPEED_10M) ? DW'(DIV_10M - 1) : DW'(DIV_100M - 1);
    w_div_nxt = (r_div_cnt >= w_div_max) ? '0 : r_div_cnt + DW'(1);
  end

  // The strobe register tracks the next count, so it is high in the same cycle the count sits at zero.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_div_cnt <= '0;
      r_clk_en  <= 1'b1;
    end else if (i_clr) begin
      r_div_cnt <= '0;
      r_clk_en  <= 1'b1;
    end else if (i_gate) begin
      r_div_cnt <= '0;
      r_clk_en  <= 1'b0;
    end else if (i_speed == SPEED_1G) begin
      r_div_cnt <= '0;
      r_clk_en  <= 1'b1;
    end else begin
      r_div_cnt <= w_div_nxt;
      r_clk_en  <= (w_div_nxt == '0);
    end
  end

  assign o_clk_en = r_clk_en;

endmodule

// File: rtl/eth_rx_speed_ctrl.sv
// Link-speed controller: sequences host speed requests through an idle-line
// drain before switching, and keeps saturating receive statistics counters.
module eth_rx_speed_ctrl
  import eth_speed_pkg::*;
#(
  parameter int DIV_100M      = 5,
  parameter int DIV_10M       = 50,
  parameter int IDLE_CYCLES   = 12,
  parameter int DRAIN_TIMEOUT = 4096,
  parameter int SETTLE_CYCLES = 16,
  parameter int CNT_WIDTH     = 32
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [1:0]           cfg_speed,
  input  logic                 cfg_valid,
  output logic                 cfg_ready,
  input  logic                 gmii_rx_dv,
  input  logic                 rx_start_packet,
  input  logic                 rx_error_bad_frame,
  input  logic                 rx_error_bad_fcs,
  output logic                 clk_enable,
  output logic                 mii_select,
  output logic [1:0]           speed,
  output logic                 switching,
  output logic                 cfg_forced,
  input  logic                 stats_clear,
  output logic [CNT_WIDTH-1:0] frame_count,
  output logic [CNT_WIDTH-1:0] bad_frame_count,
  output logic [CNT_WIDTH-1:0] bad_fcs_count
);

  localparam int TMR_MAX = (DRAIN_TIMEOUT > SETTLE_CYCLES) ? DRAIN_TIMEOUT : SETTLE_CYCLES;
  localparam int TW      = $clog2(TMR_MAX + 1);
  localparam int IW      = $clog2(IDLE_CYCLES + 1);

  ctrl_state_t          r_state, w_state_nxt;
  logic [1:0]           r_speed, r_target;
  logic                 r_mii, r_forced;
  logic [IW-1:0]        r_idle_cnt;
  logic [TW-1:0]        r_tmr;
  logic                 w_hs, w_idle_done, w_tmo_done;
  logic [CNT_WIDTH-1:0] r_frame_cnt, r_bad_frame_cnt, r_bad_fcs_cnt;

  function automatic logic [CNT_WIDTH-1:0] sat_inc(input logic [CNT_WIDTH-1:0] v);
    return (v == '1) ? v : v + CNT_WIDTH'(1);
  endfunction

  assign w_hs        = cfg_valid && (r_state == RUN);
  assign w_idle_done = (r_state == DRAIN) && !gmii_rx_dv && (r_idle_cnt == IW'(IDLE_CYCLES - 1));
  assign w_tmo_done  = (r_state == DRAIN) && (r_tmr == TW'(DRAIN_TIMEOUT - 1));

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      RUN:    if (w_hs && cfg_speed != r_speed && cfg_speed != SPEED_RSVD) w_state_nxt = DRAIN;
      DRAIN:  if (w_idle_done || w_tmo_done) w_state_nxt = SWITCH;
      SWITCH: w_state_nxt = SETTLE;
      SETTLE: if (r_tmr == TW'(SETTLE_CYCLES - 1)) w_state_nxt = RUN;
      default: w_state_nxt = RUN;
    endcase
  end

  // One timer serves both the drain timeout and the settle interval; it restarts on every state change.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= RUN;
      r_speed    <= SPEED_1G;
      r_target   <= SPEED_1G;
      r_mii      <= 1'b0;
      r_forced   <= 1'b0;
      r_idle_cnt <= '0;
      r_tmr      <= '0;
    end else begin
      r_state  <= w_state_nxt;
      r_forced <= w_tmo_done && !w_idle_done;
      if (w_state_nxt != r_state) r_tmr <= '0;
      else if (r_tmr != '1)       r_tmr <= r_tmr + TW'(1);
      if (r_state != DRAIN || gmii_rx_dv) r_idle_cnt <= '0;
      else                                r_idle_cnt <= r_idle_cnt + IW'(1);
      if (r_state == RUN && w_state_nxt == DRAIN) r_target <= cfg_speed;
      if (r_state == SWITCH) begin
        r_speed <= r_target;
        r_mii   <= is_mii(r_target);
      end
    end
  end

  eth_clk_en_gen #(
    .DIV_100M (DIV_100M),
    .DIV_10M  (DIV_10M)
  ) u_clk_en_gen (
    .clk      (clk),
    .rst_n    (rst_n),
    .i_speed  (r_speed),
    .i_clr    (r_state == SWITCH),
    .i_gate   (r_state == DRAIN && w_state_nxt == SWITCH),
    .o_clk_en (clk_enable)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_frame_cnt     <= '0;
      r_bad_frame_cnt <= '0;
      r_bad_fcs_cnt   <= '0;
    end else if (stats_clear) begin
      r_frame_cnt     <= '0;
      r_bad_frame_cnt <= '0;
      r_bad_fcs_cnt   <= '0;
    end else begin
      if (rx_start_packet)    r_frame_cnt     <= sat_inc(r_frame_cnt);
      if (rx_error_bad_frame) r_bad_frame_cnt <= sat_inc(r_bad_frame_cnt);
      if (rx_error_bad_fcs)   r_bad_fcs_cnt   <= sat_inc(r_bad_fcs_cnt);
    end
  end

  assign cfg_ready       = (r_state == RUN);
  assign switching       = (r_state != RUN);
  assign speed           = r_speed;
  assign mii_select      = r_mii;
  assign cfg_forced      = r_forced;
  assign frame_count     = r_frame_cnt;
  assign bad_frame_count = r_bad_frame_cnt;
  assign bad_fcs_count   = r_bad_fcs_cnt;

endmodule

// File: tb/tb_eth_rx_speed_ctrl.sv
// Directed bench for eth_rx_speed_ctrl: expectations are queued as stimulus
// is applied and popped as the corresponding DUT behaviour is observed.
module tb_eth_rx_speed_ctrl;

  localparam int CW = 4;

  logic          clk = 1'b0;
  logic          rst_n;
  logic [1:0]    cfg_speed;
  logic          cfg_valid, cfg_ready;
  logic          gmii_rx_dv, rx_start_packet, rx_error_bad_frame, rx_error_bad_fcs;
  logic          clk_enable, mii_select, switching, cfg_forced, stats_clear;
  logic [1:0]    speed;
  logic [CW-1:0] frame_count, bad_frame_count, bad_fcs_count;

  always #5 clk = ~clk;

  eth_rx_speed_ctrl #(.CNT_WIDTH(CW)) dut (
    .clk                (clk),
    .rst_n              (rst_n),
    .cfg_speed          (cfg_speed),
    .cfg_valid          (cfg_valid),
    .cfg_ready          (cfg_ready),
    .gmii_rx_dv         (gmii_rx_dv),
    .rx_start_packet    (rx_start_packet),
    .rx_error_bad_frame (rx_error_bad_frame),
    .rx_error_bad_fcs   (rx_error_bad_fcs),
    .clk_enable         (clk_enable),
    .mii_select         (mii_select),
    .speed              (speed),
    .switching          (switching),
    .cfg_forced         (cfg_forced),
    .stats_clear        (stats_clear),
    .frame_count        (frame_count),
    .bad_frame_count    (bad_frame_count),
    .bad_fcs_count      (bad_fcs_count)
  );

  typedef struct {
    string       tag;
    logic [31:0] exp;
  } sb_t;

  sb_t sb_q[$];
  int  checks   = 0;
  int  failures = 0;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic expect_val(input string tag, input logic [31:0] e);
    sb_t s;
    s.tag = tag;
    s.exp = e;
    sb_q.push_back(s);
  endtask

  task automatic check(input logic [31:0] obs);
    sb_t s;
    checks++;
    if (sb_q.size() == 0) begin
      failures++;
      $error("FAIL sb_underflow observed=%0d expected=none", obs);
    end else begin
      s = sb_q.pop_front();
      assert (obs === s.exp) else begin
        failures++;
        $error("FAIL %s observed=%0d expected=%0d", s.tag, obs, s.exp);
      end
    end
  endtask

  task automatic chk_now(input string tag, input logic [31:0] obs, input logic [31:0] e);
    expect_val(tag, e);
    check(obs);
  endtask

  task automatic measure_gap(output int gap);
    int k;
    k = 0;
    while (!clk_enable && k < 200) begin tick(); k++; end
    tick();
    gap = 1;
    while (!clk_enable && gap < 200) begin tick(); gap++; end
  endtask

  task automatic request(input logic [1:0] spd);
    cfg_speed = spd;
    cfg_valid = 1'b1;
    tick();
    cfg_valid = 1'b0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int n, p, a, b, fp, k, gap, forced;
    rst_n = 1'b0; cfg_speed = 2'b00; cfg_valid = 1'b0; gmii_rx_dv = 1'b0;
    rx_start_packet = 1'b0; rx_error_bad_frame = 1'b0; rx_error_bad_fcs = 1'b0; stats_clear = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    tick();

    // Reset state
    chk_now("rst_speed", speed, 2);
    chk_now("rst_mii", mii_select, 0);
    chk_now("rst_ready", cfg_ready, 1);
    chk_now("rst_switching", switching, 0);
    chk_now("rst_forced", cfg_forced, 0);
    chk_now("rst_counts", {frame_count, bad_frame_count, bad_fcs_count}, 0);
    n = 0;
    repeat (10) begin n += int'(clk_enable); tick(); end
    chk_now("rst_clk_en_ones", n, 10);

    // 1G -> 100M with idle line
    expect_val("t2_drain_len", 12);
    expect_val("t2_switch_clk_en", 0);
    expect_val("t2_switch_mii", 0);
    expect_val("t2_settle_mii", 1);
    expect_val("t2_settle_speed", 1);
    expect_val("t2_settle_len", 16);
    expect_val("t2_settle_pulses", 4);
    expect_val("t2_run_period", 5);
    expect_val("t2_forced", 0);
    gmii_rx_dv = 1'b0;
    request(2'b01);
    forced = 0; n = 0;
    while (switching && clk_enable && n < 5000) begin forced |= int'(cfg_forced); n++; tick(); end
    check(n);
    check(clk_enable);
    check(mii_select);
    forced |= int'(cfg_forced);
    tick();
    check(mii_select);
    check(speed);
    n = 0; p = 0;
    while (switching && n < 100) begin p += int'(clk_enable); forced |= int'(cfg_forced); n++; tick(); end
    check(n);
    check(p);
    measure_gap(gap);
    check(gap);
    check(forced);

    // 100M -> 10M while the line is busy for 300 cycles
    expect_val("t3_hold_switching", 300);
    expect_val("t3_hold_speed", 300);
    expect_val("t3_cycles_to_switch", 13);
    expect_val("t3_mii", 1);
    expect_val("t3_period", 50);
    expect_val("t3_done", 0);
    expect_val("t3_forced", 0);
    gmii_rx_dv = 1'b1;
    request(2'b00);
    a = 0; b = 0; forced = 0;
    repeat (300) begin
      a += int'(switching);
      b += int'(speed == 2'b01);
      forced |= int'(cfg_forced);
      tick();
    end
    check(a);
    check(b);
    gmii_rx_dv = 1'b0;
    n = 0;
    while (speed == 2'b01 && n < 200) begin forced |= int'(cfg_forced); n++; tick(); end
    check(n);
    check(mii_select);
    measure_gap(gap);
    check(gap);
    check(switching);
    check(forced);

    // 10M -> 100M with dv stuck high: forced switch
    expect_val("t4_cycles_to_switch", 4097);
    expect_val("t4_forced_pulses", 1);
    expect_val("t4_speed", 1);
    gmii_rx_dv = 1'b1;
    request(2'b01);
    n = 0; fp = 0;
    while (speed == 2'b00 && n < 6000) begin fp += int'(cfg_forced); n++; tick(); end
    check(n);
    k = 0;
    while (switching && k < 100) begin fp += int'(cfg_forced); k++; tick(); end
    check(fp);
    check(speed);
    gmii_rx_dv = 1'b0;

    // Move to 1G, then same-speed and reserved requests are consumed in RUN
    expect_val("t5_speed", 2);
    expect_val("t5_mii", 0);
    expect_val("t5_clk_ones", 8);
    expect_val("t5_same_switching", 0);
    expect_val("t5_rsvd_switching", 0);
    expect_val("t5_speed_after", 2);
    expect_val("t5_ready", 1);
    request(2'b10);
    k = 0;
    while (switching && k < 200) begin k++; tick(); end
    check(speed);
    check(mii_select);
    n = 0;
    repeat (8) begin n += int'(clk_enable); tick(); end
    check(n);
    request(2'b10);
    a = 0;
    repeat (4) begin a += int'(switching); tick(); end
    check(a);
    request(2'b11);
    a = 0;
    repeat (4) begin a += int'(switching); tick(); end
    check(a);
    check(speed);
    check(cfg_ready);

    // Statistics counters: latency, saturation, clear priority
    expect_val("t6_frame_first", 1);
    expect_val("t6_frame_sat", 15);
    expect_val("t6_bad_frame", 3);
    expect_val("t6_bad_fcs", 1);
    expect_val("t6_clr_frame", 0);
    expect_val("t6_clr_bad_frame", 0);
    expect_val("t6_clr_bad_fcs", 0);
    expect_val("t6_after_clr", 1);
    rx_start_packet = 1'b1;
    tick();
    rx_start_packet = 1'b0;
    check(frame_count);
    for (int i = 0; i < 16; i++) begin
      rx_start_packet    = 1'b1;
      rx_error_bad_frame = (i < 3);
      rx_error_bad_fcs   = (i == 0);
      tick();
    end
    rx_start_packet = 1'b0; rx_error_bad_frame = 1'b0; rx_error_bad_fcs = 1'b0;
    check(frame_count);
    check(bad_frame_count);
    check(bad_fcs_count);
    stats_clear = 1'b1; rx_start_packet = 1'b1; rx_error_bad_frame = 1'b1; rx_error_bad_fcs = 1'b1;
    tick();
    stats_clear = 1'b0; rx_error_bad_frame = 1'b0; rx_error_bad_fcs = 1'b0;
    check(frame_count);
    check(bad_frame_count);
    check(bad_fcs_count);
    tick();
    rx_start_packet = 1'b0;
    check(frame_count);

    // Asynchronous reset in the middle of SETTLE
    expect_val("t6_mid_settle", 1);
    expect_val("t6_rst_speed", 2);
    expect_val("t6_rst_switching", 0);
    expect_val("t6_rst_mii", 0);
    expect_val("t6_rst_clk_en", 1);
    expect_val("t6_rst_ready", 1);
    expect_val("t6_rst_frame", 0);
    expect_val("t6_post_rst_switching", 0);
    expect_val("t6_post_rst_speed", 2);
    request(2'b01);
    k = 0;
    while (!mii_select && k < 100) begin k++; tick(); end
    repeat (3) tick();
    check(switching);
    #2 rst_n = 1'b0;
    #1;
    check(speed);
    check(switching);
    check(mii_select);
    check(clk_enable);
    check(cfg_ready);
    check(frame_count);
    @(posedge clk);
    #1 rst_n = 1'b1;
    tick();
    check(switching);
    check(speed);

    checks++;
    assert (sb_q.size() == 0) else begin
      failures++;
      $error("FAIL sb_leftover observed=%0d expected=0", sb_q.size());
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
